// File: rtl/i3c_bus_model.sv
// Behavioural I3C/I2C bus resolver: wired-AND line resolution, START/STOP
// tracking, SCL edge counting, idle timing and push-pull contention monitoring.
module i3c_bus_model #(
    parameter int NumDevices = 3,
    parameter int CntW       = 16,
    parameter int ContW      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NumDevices-1:0] sda_i,
    input  logic [NumDevices-1:0] scl_i,
    input  logic [NumDevices-1:0] sel_od_pp_i,
    input  logic [NumDevices-1:0] dev_en_i,
    input  logic [CntW-1:0]       t_idle_i,
    input  logic                  cont_clr_i,
    output logic                  bus_sda_o,
    output logic                  bus_scl_o,
    output logic                  start_o,
    output logic                  rstart_o,
    output logic                  stop_o,
    output logic                  bus_busy_o,
    output logic                  bus_idle_o,
    output logic [CntW-1:0]       scl_rise_cnt_o,
    output logic [ContW-1:0]      cont_cnt_o,
    output logic [NumDevices-1:0] cont_dev_o
);

    function automatic logic [CntW-1:0] sat_inc_cnt(input logic [CntW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [ContW-1:0] sat_inc_cont(input logic [ContW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [NumDevices-1:0] sda_eff;
    logic [NumDevices-1:0] scl_eff;
    logic [NumDevices-1:0] pp_en;
    logic [NumDevices-1:0] sda_hi_pp;
    logic [NumDevices-1:0] scl_hi_pp;
    logic [NumDevices-1:0] sda_lo;
    logic [NumDevices-1:0] scl_lo;
    logic [NumDevices-1:0] offenders;
    logic                  sda_cont;
    logic                  scl_cont;
    logic                  cont_now;

    logic                  sda_q;
    logic                  scl_q;
    logic                  track_en;
    logic                  start_cond;
    logic                  stop_cond;
    logic                  start_det;
    logic                  stop_det;
    logic                  scl_rise;
    logic [CntW-1:0]       idle_cnt;

    // A disabled device releases both lines.
    assign sda_eff   = sda_i | ~dev_en_i;
    assign scl_eff   = scl_i | ~dev_en_i;
    assign bus_sda_o = &sda_eff;
    assign bus_scl_o = &scl_eff;

    assign pp_en     = sel_od_pp_i & dev_en_i;
    assign sda_hi_pp = pp_en & sda_i;
    assign scl_hi_pp = pp_en & scl_i;
    assign sda_lo    = dev_en_i & ~sda_i;
    assign scl_lo    = dev_en_i & ~scl_i;
    assign sda_cont  = (|sda_hi_pp) && (|sda_lo);
    assign scl_cont  = (|scl_hi_pp) && (|scl_lo);
    assign cont_now  = sda_cont || scl_cont;
    assign offenders = (sda_cont ? sda_hi_pp : '0) | (scl_cont ? scl_hi_pp : '0);

    // START and STOP differ in the sda_q term, so they can never coincide.
    assign start_cond = scl_q & bus_scl_o &  sda_q & ~bus_sda_o;
    assign stop_cond  = scl_q & bus_scl_o & ~sda_q &  bus_sda_o;
    // The first cycle out of reset compares against forced sda_q/scl_q, so it is ignored.
    assign start_det  = track_en & start_cond;
    assign stop_det   = track_en & stop_cond;
    assign scl_rise   = ~scl_q & bus_scl_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sda_q      <= 1'b1;
            scl_q      <= 1'b1;
            track_en   <= 1'b0;
            start_o    <= 1'b0;
            rstart_o   <= 1'b0;
            stop_o     <= 1'b0;
            bus_busy_o <= 1'b0;
        end else begin
            sda_q    <= bus_sda_o;
            scl_q    <= bus_scl_o;
            track_en <= 1'b1;
            start_o  <= start_det & ~bus_busy_o;
            rstart_o <= start_det &  bus_busy_o;
            stop_o   <= stop_det;
            if (start_det) begin
                bus_busy_o <= 1'b1;
            end else if (stop_det) begin
                bus_busy_o <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_rise_cnt_o <= '0;
        end else if (start_det) begin
            scl_rise_cnt_o <= '0;
        end else if (scl_rise) begin
            scl_rise_cnt_o <= sat_inc_cnt(scl_rise_cnt_o);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idle_cnt <= '0;
        end else if (bus_busy_o || !bus_sda_o || !bus_scl_o) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= sat_inc_cnt(idle_cnt);
        end
    end

    // A zero threshold means "idle as soon as both lines are high".
    assign bus_idle_o = ~bus_busy_o &
                        ((t_idle_i == '0) ? (bus_sda_o & bus_scl_o) : (idle_cnt >= t_idle_i));

    // A clear coinciding with contention restarts the record from this cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cont_cnt_o <= '0;
            cont_dev_o <= '0;
        end else if (cont_clr_i) begin
            cont_cnt_o <= cont_now ? ContW'(1) : '0;
            cont_dev_o <= cont_now ? offenders : '0;
        end else if (cont_now) begin
            cont_cnt_o <= sat_inc_cont(cont_cnt_o);
            cont_dev_o <= cont_dev_o | offenders;
        end
    end

endmodule

// File: tb/tb_i3c_bus_model.sv
// Directed bench for i3c_bus_model: combinational/contention vector table plus
// hand-written START, repeated START, STOP, idle, saturation and reset sequences.
module tb_i3c_bus_model;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  sda;
    logic [2:0]  scl;
    logic [2:0]  pp;
    logic [2:0]  en;
    logic [15:0] t_idle;
    logic        cont_clr;
    logic        bus_sda;
    logic        bus_scl;
    logic        start;
    logic        rstart;
    logic        stop;
    logic        busy;
    logic        idle;
    logic [15:0] rise_cnt;
    logic [7:0]  cont_cnt;
    logic [2:0]  cont_dev;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    i3c_bus_model #(.NumDevices(3), .CntW(16), .ContW(8)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .sda_i         (sda),
        .scl_i         (scl),
        .sel_od_pp_i   (pp),
        .dev_en_i      (en),
        .t_idle_i      (t_idle),
        .cont_clr_i    (cont_clr),
        .bus_sda_o     (bus_sda),
        .bus_scl_o     (bus_scl),
        .start_o       (start),
        .rstart_o      (rstart),
        .stop_o        (stop),
        .bus_busy_o    (busy),
        .bus_idle_o    (idle),
        .scl_rise_cnt_o(rise_cnt),
        .cont_cnt_o    (cont_cnt),
        .cont_dev_o    (cont_dev)
    );

    typedef struct {
        logic [2:0] sda;
        logic [2:0] scl;
        logic [2:0] pp;
        logic [2:0] en;
        logic       bs;
        logic       bc;
        logic [7:0] cnt;
        logic [2:0] dev;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        //            sda     scl     pp      en      bs    bc    cnt  dev
        vecs[0] = '{3'b111, 3'b111, 3'b000, 3'b111, 1'b1, 1'b1, 8'd0, 3'b000};
        vecs[1] = '{3'b110, 3'b111, 3'b000, 3'b111, 1'b0, 1'b1, 8'd0, 3'b000};
        vecs[2] = '{3'b110, 3'b111, 3'b100, 3'b111, 1'b0, 1'b1, 8'd1, 3'b100};
        vecs[3] = '{3'b111, 3'b011, 3'b110, 3'b111, 1'b1, 1'b0, 8'd1, 3'b010};
        vecs[4] = '{3'b110, 3'b111, 3'b111, 3'b110, 1'b1, 1'b1, 8'd0, 3'b000};
        vecs[5] = '{3'b010, 3'b101, 3'b101, 3'b111, 1'b0, 1'b0, 8'd1, 3'b101};
        vecs[6] = '{3'b011, 3'b111, 3'b011, 3'b011, 1'b1, 1'b1, 8'd0, 3'b000};
        vecs[7] = '{3'b001, 3'b110, 3'b111, 3'b111, 1'b0, 1'b0, 8'd1, 3'b111};
        vecs[8] = '{3'b000, 3'b000, 3'b111, 3'b111, 1'b0, 1'b0, 8'd0, 3'b000};
        vecs[9] = '{3'b000, 3'b000, 3'b111, 3'b000, 1'b1, 1'b1, 8'd0, 3'b000};

        rst = 1'b1; sda = 3'b111; scl = 3'b111; pp = 3'b000; en = 3'b111;
        t_idle = 16'd5; cont_clr = 1'b0;
        step(2);
        check("rst_busy",     busy,     0);
        check("rst_start",    start,    0);
        check("rst_rstart",   rstart,   0);
        check("rst_stop",     stop,     0);
        check("rst_rise_cnt", rise_cnt, 0);
        check("rst_cont_cnt", cont_cnt, 0);
        check("rst_cont_dev", cont_dev, 0);
        check("rst_idle",     idle,     0);
        check("rst_bus_sda",  bus_sda,  1);
        rst = 1'b0;
        step(2);

        // Table: line resolution, contention detection and clear-with-contention.
        for (int i = 0; i < 10; i++) begin
            sda = vecs[i].sda; scl = vecs[i].scl; pp = vecs[i].pp; en = vecs[i].en;
            cont_clr = 1'b1;
            #1;
            check($sformatf("vec%0d_bus_sda", i), bus_sda, vecs[i].bs);
            check($sformatf("vec%0d_bus_scl", i), bus_scl, vecs[i].bc);
            step(1);
            check($sformatf("vec%0d_cont_cnt", i), cont_cnt, vecs[i].cnt);
            check($sformatf("vec%0d_cont_dev", i), cont_dev, vecs[i].dev);
        end
        cont_clr = 1'b0; sda = 3'b111; scl = 3'b111; pp = 3'b000; en = 3'b111;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(2);

        // START: dev1 pulls SDA with SCL high.
        sda = 3'b101;
        #1;
        check("start_pre_pulse", start, 0);
        step(1);
        check("start_pulse",    start,    1);
        check("start_busy",     busy,     1);
        check("start_rise_cnt", rise_cnt, 0);
        check("start_no_rstart", rstart,  0);
        step(1);
        check("start_one_cycle", start, 0);

        // Nine SCL pulses; SDA released during the last low phase.
        for (int i = 0; i < 9; i++) begin
            scl = 3'b101;
            step(1);
            if (i == 8) begin
                sda = 3'b111;
                step(1);
            end
            scl = 3'b111;
            step(1);
        end
        check("rise_cnt_9", rise_cnt, 9);
        check("busy_during_xfer", busy, 1);
        sda = 3'b101;
        step(1);
        check("rstart_pulse",    rstart,   1);
        check("rstart_no_start", start,    0);
        check("rstart_rise_cnt", rise_cnt, 0);
        check("rstart_busy",     busy,     1);
        step(1);
        check("rstart_one_cycle", rstart, 0);

        // STOP and idle threshold of 5.
        sda = 3'b111;
        step(1);
        check("stop_pulse", stop, 1);
        check("stop_busy",  busy, 0);
        check("stop_idle",  idle, 0);
        step(1);
        check("stop_one_cycle", stop, 0);
        step(3);
        check("idle_before_thr", idle, 0);
        step(1);
        check("idle_at_thr", idle, 1);

        // STOP while not busy still pulses.
        sda = 3'b101; scl = 3'b101;
        step(1);
        scl = 3'b111;
        step(1);
        check("no_start_on_sda_scl_fall", busy, 0);
        sda = 3'b111;
        step(1);
        check("idle_stop_pulse", stop,  1);
        check("idle_stop_busy",  busy,  0);
        check("idle_stop_start", start, 0);

        // Zero threshold follows the lines directly.
        t_idle = 16'd0;
        #1;
        check("thr0_idle_high", idle, 1);
        scl = 3'b110;
        #1;
        check("thr0_idle_scl_low", idle, 0);
        step(1);

        // Push-pull dev2 fights open-drain dev0 on SDA for 3 cycles.
        cont_clr = 1'b1;
        step(1);
        cont_clr = 1'b0;
        pp = 3'b100; sda = 3'b110;
        #1;
        check("cont_bus_sda", bus_sda, 0);
        step(3);
        sda = 3'b111; pp = 3'b000;
        check("cont_cnt_3", cont_cnt, 3);
        check("cont_dev_3", cont_dev, 3'b100);

        // Disabled dev0 pulling low is ignored.
        en = 3'b110; sda = 3'b110; scl = 3'b110;
        #1;
        check("dis_bus_sda", bus_sda, 1);
        check("dis_bus_scl", bus_scl, 1);
        cont_clr = 1'b1;
        step(1);
        cont_clr = 1'b0;
        check("dis_clr_cnt", cont_cnt, 0);
        en = 3'b111; pp = 3'b100;
        step(300);
        check("cont_sat_cnt", cont_cnt, 255);
        check("cont_sat_dev", cont_dev, 3'b100);
        sda = 3'b111; scl = 3'b111; pp = 3'b000;
        cont_clr = 1'b1;
        step(1);
        cont_clr = 1'b0;
        check("clr_cnt", cont_cnt, 0);
        check("clr_dev", cont_dev, 0);
        step(1);

        // Reset mid-transfer.
        sda = 3'b101;
        step(1);
        check("pre_rst_start", start, 1);
        check("pre_rst_busy",  busy,  1);
        rst = 1'b1;
        step(1);
        check("mid_rst_busy",     busy,     0);
        check("mid_rst_start",    start,    0);
        check("mid_rst_rise_cnt", rise_cnt, 0);
        check("mid_rst_cont_cnt", cont_cnt, 0);
        check("mid_rst_bus_sda",  bus_sda,  0);
        rst = 1'b0;
        step(1);
        check("post_rst1_start", start, 0);
        check("post_rst1_stop",  stop,  0);
        check("post_rst1_busy",  busy,  0);
        step(1);
        check("post_rst2_start", start, 0);
        check("post_rst2_stop",  stop,  0);
        check("post_rst2_busy",  busy,  0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
